// File: rtl/tron_pkg.sv
// Shared definitions for the Tron board controller: state encoding, cell codes
// and default board geometry.
package tron_pkg;

  localparam int BOARD_ADDR_W = 8;
  localparam int BOARD_DATA_W = 16;

  localparam logic [BOARD_DATA_W-1:0] EMPTY_CODE = 16'd0;
  localparam logic [BOARD_DATA_W-1:0] P1_CODE    = 16'd1;
  localparam logic [BOARD_DATA_W-1:0] P2_CODE    = 16'd2;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_READY = 3'd2,
    ST_READ  = 3'd3,
    ST_CHECK = 3'd4,
    ST_WRITE = 3'd5
  } state_e;

endpackage

// File: rtl/tron_board_ctrl.sv
// Board controller in front of a dual-port registered-read memory: clears the
// board, reads both players' next cells, writes trails and reports crashes.
module tron_board_ctrl #(
  parameter int                         ADDR_W  = tron_pkg::BOARD_ADDR_W,
  parameter int                         DATA_W  = tron_pkg::BOARD_DATA_W,
  parameter logic [tron_pkg::BOARD_DATA_W-1:0] P1_CODE = tron_pkg::P1_CODE,
  parameter logic [tron_pkg::BOARD_DATA_W-1:0] P2_CODE = tron_pkg::P2_CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              move_valid,
  output logic              move_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [ADDR_W-1:0] p2_addr,
  output logic              result_valid,
  output logic              p1_crash,
  output logic              p2_crash,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] dataIn1,
  output logic [DATA_W-1:0] dataIn2,
  output logic              we1,
  output logic              we2,
  input  logic [DATA_W-1:0] dataOut1,
  input  logic [DATA_W-1:0] dataOut2,
  output logic [2:0]        state_dbg
);
  import tron_pkg::*;

  // Handshake: a move is taken on a rising edge where move_valid && move_ready;
  // move_ready is only high in READY with no clear pending, and clear has priority.

  localparam logic [ADDR_W-2:0] CLR_LAST = '1;
  localparam logic [DATA_W-1:0] EMPTY_W  = DATA_W'(EMPTY_CODE);
  localparam logic [DATA_W-1:0] P1_W     = DATA_W'(P1_CODE);
  localparam logic [DATA_W-1:0] P2_W     = DATA_W'(P2_CODE);

  state_e            state_q, state_d;
  logic [ADDR_W-2:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0] din1_q, din1_d, din2_q, din2_d;
  logic              we1_q, we1_d, we2_q, we2_d;
  logic              p1_crash_q, p1_crash_d, p2_crash_q, p2_crash_d;
  logic              same_cell, c1, c2;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  state_d = ST_CLEAR;
      ST_CLEAR: if (clr_cnt_q == CLR_LAST) state_d = ST_READY;
      ST_READY: begin
        if (clear_req)       state_d = ST_CLEAR;
        else if (move_valid) state_d = ST_READ;
      end
      ST_READ:  state_d = ST_CHECK;
      ST_CHECK: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // Head-on moves crash both players, which also keeps the ports off one address.
  assign same_cell = (addr1_q == addr2_q);
  assign c1 = (dataOut1 != EMPTY_W) || same_cell;
  assign c2 = (dataOut2 != EMPTY_W) || same_cell;

  // Output / datapath next values; everything lands on the edge entering its state
  always_comb begin
    clr_cnt_d  = clr_cnt_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    din1_d     = din1_q;
    din2_d     = din2_q;
    we1_d      = 1'b0;
    we2_d      = 1'b0;
    p1_crash_d = p1_crash_q;
    p2_crash_d = p2_crash_q;
    unique case (state_q)
      ST_INIT: begin
        clr_cnt_d = '0;
        addr1_d   = {{(ADDR_W-1){1'b0}}, 1'b0};
        addr2_d   = {{(ADDR_W-1){1'b0}}, 1'b1};
        din1_d    = EMPTY_W;
        din2_d    = EMPTY_W;
        we1_d     = 1'b1;
        we2_d     = 1'b1;
      end
      ST_CLEAR: begin
        if (clr_cnt_q != CLR_LAST) begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          addr1_d   = {clr_cnt_q + 1'b1, 1'b0};
          addr2_d   = {clr_cnt_q + 1'b1, 1'b1};
          din1_d    = EMPTY_W;
          din2_d    = EMPTY_W;
          we1_d     = 1'b1;
          we2_d     = 1'b1;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          clr_cnt_d = '0;
          addr1_d   = {{(ADDR_W-1){1'b0}}, 1'b0};
          addr2_d   = {{(ADDR_W-1){1'b0}}, 1'b1};
          din1_d    = EMPTY_W;
          din2_d    = EMPTY_W;
          we1_d     = 1'b1;
          we2_d     = 1'b1;
        end else if (move_valid) begin
          addr1_d = p1_addr;
          addr2_d = p2_addr;
        end
      end
      ST_CHECK: begin
        p1_crash_d = c1;
        p2_crash_d = c2;
        din1_d     = P1_W;
        din2_d     = P2_W;
        we1_d      = !c1;
        we2_d      = !c2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt_q  <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      din1_q     <= '0;
      din2_q     <= '0;
      we1_q      <= 1'b0;
      we2_q      <= 1'b0;
      p1_crash_q <= 1'b0;
      p2_crash_q <= 1'b0;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      din1_q     <= din1_d;
      din2_q     <= din2_d;
      we1_q      <= we1_d;
      we2_q      <= we2_d;
      p1_crash_q <= p1_crash_d;
      p2_crash_q <= p2_crash_d;
    end
  end

  assign move_ready   = (state_q == ST_READY) && !clear_req;
  assign result_valid = (state_q == ST_WRITE);
  assign clear_busy   = (state_q == ST_CLEAR);
  assign addr1        = addr1_q;
  assign addr2        = addr2_q;
  assign dataIn1      = din1_q;
  assign dataIn2      = din2_q;
  assign we1          = we1_q;
  assign we2          = we2_q;
  assign p1_crash     = p1_crash_q;
  assign p2_crash     = p2_crash_q;
  assign state_dbg    = 3'(state_q);

endmodule

// File: tb/tb_tron_board_ctrl.sv
// Directed bench for tron_board_ctrl with a behavioural 256x16 dual-port
// registered-read board memory.
module tb_tron_board_ctrl;
  import tron_pkg::*;

  logic        clk, reset, clear_req, move_valid, move_ready;
  logic [7:0]  p1_addr, p2_addr, addr1, addr2;
  logic        result_valid, p1_crash, p2_crash, clear_busy, we1, we2;
  logic [15:0] dataIn1, dataIn2, dataOut1, dataOut2;
  logic [2:0]  state_dbg;
  logic [15:0] mem [0:255];
  logic [1:0]  exp_q[$];

  int checks = 0;
  int errors = 0;

  tron_board_ctrl dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .move_valid(move_valid),
    .move_ready(move_ready), .p1_addr(p1_addr), .p2_addr(p2_addr),
    .result_valid(result_valid), .p1_crash(p1_crash), .p2_crash(p2_crash),
    .clear_busy(clear_busy), .addr1(addr1), .addr2(addr2),
    .dataIn1(dataIn1), .dataIn2(dataIn2), .we1(we1), .we2(we2),
    .dataOut1(dataOut1), .dataOut2(dataOut2), .state_dbg(state_dbg)
  );

  // Clock / board memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we1) mem[addr1] <= dataIn1;
    if (we2) mem[addr2] <= dataIn2;
    dataOut1 <= mem[addr1];
    dataOut2 <= mem[addr2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts CLEAR cycles until move_ready rises; checks ready follows directly.
  task automatic run_clear(input string tag);
    int  busy;
    bit  done;
    logic prev_busy;
    busy = 0;
    done = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (clear_busy) busy++;
      else if (move_ready) begin
        done = 1;
        check({tag, "_ready_after_last_clear"}, 32'(prev_busy), 32'd1);
      end
      prev_busy = clear_busy;
    end
    check({tag, "_ready_reached"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy), 32'd128);
  endtask

  // Issues a move from READY and checks latency, crash flags and write enables.
  task automatic do_move(input string tag, input logic [7:0] a1, input logic [7:0] a2,
                         input logic c1, input logic c2);
    int   lat;
    bit   seen;
    logic [1:0] exp;
    exp_q.push_back({c1, c2});
    check({tag, "_ready_before"}, 32'(move_ready), 32'd1);
    p1_addr = a1;
    p2_addr = a2;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    lat = 0;
    seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1;
        lat = i;
      end
    end
    check({tag, "_result_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    exp = exp_q.pop_front();
    check({tag, "_crash"}, {30'd0, p1_crash, p2_crash}, {30'd0, exp});
    check({tag, "_we"}, {30'd0, we1, we2}, {30'd0, ~exp});
    @(negedge clk);
    check({tag, "_ready_after"}, {30'd0, move_ready, result_valid}, 32'd2);
  endtask

  initial begin
    int nonzero;
    reset = 1'b0;
    clear_req = 1'b0;
    move_valid = 1'b0;
    p1_addr = '0;
    p2_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    #1;
    check("rst_outputs", {clear_busy, move_ready, result_valid, we1, we2, p1_crash, p2_crash},
          32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_INIT));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("init_load", {we1, we2, addr1, addr2, dataIn1}, {1'b1, 1'b1, 8'd0, 8'd1, 16'd0});
    run_clear("clear0");
    nonzero = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 16'd0) nonzero++;
    check("clear0_board_zero", 32'(nonzero), 32'd0);

    do_move("mv1", 8'd10, 8'd20, 1'b0, 1'b0);
    check("mv1_mem10", 32'(mem[10]), 32'd1);
    check("mv1_mem20", 32'(mem[20]), 32'd2);

    do_move("mv2", 8'd20, 8'd30, 1'b1, 1'b0);
    check("mv2_mem20", 32'(mem[20]), 32'd2);
    check("mv2_mem30", 32'(mem[30]), 32'd2);

    do_move("mv3", 8'd40, 8'd40, 1'b1, 1'b1);
    check("mv3_mem40", 32'(mem[40]), 32'd0);

    // Clear and move together: clear wins
    p1_addr = 8'd70;
    p2_addr = 8'd71;
    move_valid = 1'b1;
    clear_req = 1'b1;
    #1 check("clr_req_ready_low", 32'(move_ready), 32'd0);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    clear_req = 1'b0;
    check("clr_req_state", 32'(state_dbg), 32'(ST_CLEAR));
    run_clear("clear1");
    check("clear1_mem10", 32'(mem[10]), 32'd0);
    check("clear1_mem30", 32'(mem[30]), 32'd0);
    check("clear1_mem70", 32'(mem[70]), 32'd0);
    check("clear1_flags_hold", {30'd0, p1_crash, p2_crash}, 32'd3);

    // Reset during CHECK with a move in flight
    p1_addr = 8'd50;
    p2_addr = 8'd60;
    move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_state_check", 32'(state_dbg), 32'(ST_CHECK));
    reset = 1'b0;
    #1;
    check("mid_rst_outputs", {clear_busy, move_ready, result_valid, we1, we2, p1_crash, p2_crash},
          32'd0);
    check("mid_rst_addr", {addr1, addr2, dataIn1, dataIn2}, 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_INIT));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_write", {mem[50], mem[60]}, 32'd0);
    reset = 1'b1;
    run_clear("clear2");

    do_move("mv4", 8'd50, 8'd60, 1'b0, 1'b0);
    check("mv4_mem50", 32'(mem[50]), 32'd1);
    check("mv4_mem60", 32'(mem[60]), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
